tone_player: RTL and testbench
==============================

// Module: tone_player
// PURPOSE
//  Consumer end of the 4-bit sound-code bus driven by the game/animation sequencers.
//  Converts the current code into a square-wave speaker drive (code 0 = silence).
//  Also generates the periodic one-cycle `next` step pulse that paces those sequencers.
//  Sits between the sequencers and the speaker pin; one instance per board.
// PARAMETERS
//  TICK_DIV   5_000_000  clk cycles per `next` pulse (100 ms at 50 MHz); >= 2
//  BASE_HALF  113_636    half-period (clk cycles) of code 1 (220 Hz at 50 MHz)
//  STEP       5_000      half-period decrement per code step; BASE_HALF > 14*STEP + 1
//  DIV_W      24         width of the tone and tick counters; must hold TICK_DIV-1 and BASE_HALF-1
// PORTS
//  clk          in   1      system clock; all logic on posedge
//  reset        in   1      synchronous, active-low reset
//  enable       in   1      1 = run the step tick generator
//  mute         in   1      1 = force speaker silent (tone state cleared)
//  sound        in   4      sound code from sequencer; 0 = silence, 1..15 = tone index
//  next         out  1      one-cycle step pulse to sequencers
//  speaker      out  1      square-wave drive
//  tone_active  out  1      1 while a non-zero, unmuted code is playing
// BEHAVIOUR
//  Reset (reset==0 at posedge): next=0, speaker=0, tone_active=0, code_q=0, tick_cnt=0, half_cnt=0.
//   Takes priority over everything; reset mid-tone silences on the following cycle.
//  Tick generator:
//   - enable=0: tick_cnt held at 0, next=0.
//   - enable=1: tick_cnt increments each cycle; when tick_cnt==TICK_DIV-1, next=1 for that cycle, tick_cnt->0.
//   - First pulse occurs TICK_DIV cycles after enable rises.
//   - enable falling mid-count discards the partial count.
//   - next is registered and never wider than 1 cycle.
//  Code capture: code_q <= sound every cycle (1-cycle latency; isolates sequencer clock-edge timing).
//  Half-period: HALF(c) = BASE_HALF - (c-1)*STEP for c in 1..15, computed in DIV_W bits.
//   Parameter constraint guarantees HALF(15) >= 2.
//  Tone counter, per cycle, in priority order:
//   1. sound != code_q (code change): half_cnt<=0, speaker<=0 (phase restart, always starts low).
//   2. mute==1 or code_q==0: half_cnt<=0, speaker<=0.
//   3. half_cnt==HALF(code_q)-1: half_cnt<=0, speaker<=~speaker.
//   4. Otherwise: half_cnt<=half_cnt+1.
//  Resulting latency:
//   - sound change at edge N -> code_q valid at N+1 -> first speaker rise at N+1+HALF(new).
//   - Steady state: speaker period = 2*HALF(code_q) cycles, 50% duty.
//  tone_active = registered (code_q!=0 && !mute); it updates on the same edge as code_q.
//  Simultaneous events:
//   - Code change and terminal count in the same cycle: the code change wins (no toggle).
//   - mute release: tone resumes from phase 0, low.
//   - Tick generator and tone path are fully independent.
// STRUCTURE
//  Shared package (snd_pkg): SOUND_W=4, SILENCE=4'd0, function half_period(code, BASE_HALF, STEP).
//   Shared with the sequencers so they use the same code meaning.
//  One natural sub-module: step_ticker (TICK_DIV, DIV_W; clk, reset, enable -> next).
//  Tone divider stays inline in tone_player.
// TESTING (bench params: TICK_DIV=10, BASE_HALF=40, STEP=2, DIV_W=8)
//  1. Hold reset=0 for 3 cycles with sound=5, enable=1
//     -> next=0, speaker=0, tone_active=0 throughout and on the first cycle after release.
//  2. enable=1 at cycle 0 -> next=1 exactly at cycles 10, 20, 30, each 1 cycle wide.
//     enable=0 at cycle 25, enable=1 at 27 -> next pulse at 37.
//  3. sound=1 steady -> speaker toggles every 40 cycles.
//     sound=15 -> toggles every 12 cycles; tone_active=1 in both.
//  4. sound=1 for 25 cycles into a high half, then sound=8
//     -> speaker low next cycle; first rise 1+26 cycles later (HALF(8)=26).
//  5. mute=1 mid-tone -> speaker=0 and tone_active=0 next cycle.
//     mute=0 -> first rise HALF cycles later.
//     sound=0 -> same silence behaviour.
//  6. Reset pulse mid-tone and mid-tick -> all outputs 0 next cycle.
//     After release: tick count restarts from 0; tone restarts from phase 0.

Source files
------------

// File: rtl/snd_pkg.sv
// snd_pkg: sound-code definitions shared by the tone player and the sequencers
//   SOUND_W     width of the sound-code bus
//   SILENCE     code that means "no tone"
//   half_period half-period in clk cycles for a code (code 1 = base_half)
package snd_pkg;
  localparam int unsigned SOUND_W = 4;
  localparam logic [SOUND_W-1:0] SILENCE = 4'd0;
  function automatic int unsigned half_period(input logic [SOUND_W-1:0] code,
                                              input int unsigned base_half,
                                              input int unsigned step);
    return code == SILENCE ? base_half : base_half - (32'(code) - 32'd1) * step;
  endfunction
endpackage

// File: rtl/tone_player_step_ticker.sv
// step_ticker: periodic one-cycle step pulse generator
//   clk    in  system clock
//   reset  in  synchronous active-low reset
//   enable in  1 = count; 0 = hold count at 0 (partial count discarded)
//   next   out registered pulse, high for one cycle every TICK_DIV cycles
module step_ticker #(
  parameter int unsigned TICK_DIV = 5_000_000,
  parameter int unsigned DIV_W    = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic next
);
  logic [DIV_W-1:0] tick_q, tick_d;
  logic next_q, next_d, wrap;
  always_comb begin
    wrap   = tick_q == DIV_W'(TICK_DIV - 1);
    tick_d = (!enable || wrap) ? '0 : tick_q + DIV_W'(1);
    next_d = enable && wrap;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      tick_q <= '0;
      next_q <= 1'b0;
    end else begin
      tick_q <= tick_d;
      next_q <= next_d;
    end
  end
  assign next = next_q;
endmodule

// File: rtl/tone_player.sv
// tone_player: sound code to square-wave speaker drive, plus sequencer step tick
//   clk         in  system clock
//   reset       in  synchronous active-low reset
//   enable      in  1 = run the step tick generator
//   mute        in  1 = force speaker silent, tone phase cleared
//   sound       in  sound code (0 = silence, 1..15 = tone index)
//   next        out one-cycle step pulse every TICK_DIV cycles
//   speaker     out square-wave drive, period 2*HALF(code)
//   tone_active out 1 while a non-zero unmuted code is playing
module tone_player
  import snd_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 5_000_000,
  parameter int unsigned BASE_HALF = 113_636,
  parameter int unsigned STEP      = 5_000,
  parameter int unsigned DIV_W     = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               mute,
  input  logic [SOUND_W-1:0] sound,
  output logic               next,
  output logic               speaker,
  output logic               tone_active
);
  logic [SOUND_W-1:0] code_q;
  logic [DIV_W-1:0] half_q, half_d, half_m1;
  logic spk_q, spk_d, act_q, act_d, silent, term;
  step_ticker #(.TICK_DIV(TICK_DIV), .DIV_W(DIV_W)) u_ticker (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .next   (next)
  );
  // A code change outranks the terminal count so every new tone starts low at phase 0.
  always_comb begin
    half_m1 = DIV_W'(half_period(code_q, BASE_HALF, STEP) - 32'd1);
    silent  = (sound != code_q) || mute || (code_q == SILENCE);
    term    = half_q == half_m1;
    half_d  = (silent || term) ? '0 : half_q + DIV_W'(1);
    spk_d   = silent ? 1'b0 : (term ? ~spk_q : spk_q);
    act_d   = (sound != SILENCE) && !mute;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      code_q <= SILENCE;
      half_q <= '0;
      spk_q  <= 1'b0;
      act_q  <= 1'b0;
    end else begin
      code_q <= sound;
      half_q <= half_d;
      spk_q  <= spk_d;
      act_q  <= act_d;
    end
  end
  assign speaker     = spk_q;
  assign tone_active = act_q;
endmodule

// File: tb/tb_tone_player.sv
// tb_tone_player: directed self-checking bench for tone_player
module tb_tone_player;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic mute = 1'b0;
  logic [3:0] sound = 4'd0;
  logic next, speaker, tone_active;
  logic exp;
  int checks = 0;
  int errors = 0;

  tone_player #(.TICK_DIV(10), .BASE_HALF(40), .STEP(2), .DIV_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .mute        (mute),
    .sound       (sound),
    .next        (next),
    .speaker     (speaker),
    .tone_active (tone_active)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; sound = 4'd5; enable = 1'b1; mute = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      tick_n(1);
      checks++;
      if ({next, speaker, tone_active} !== 3'b000) begin
        errors++; $display("FAIL reset_hold c=%0d outs=%b want=000", c, {next, speaker, tone_active});
      end
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({next, speaker, tone_active} !== 3'b000) begin
      errors++; $display("FAIL reset_release outs=%b want=000", {next, speaker, tone_active});
    end
    tick_n(1);
    checks++;
    if ({next, speaker, tone_active} !== 3'b001) begin
      errors++; $display("FAIL reset_first_edge outs=%b want=001", {next, speaker, tone_active});
    end
  endtask

  task automatic test_tick();
    enable = 1'b0; tick_n(1);
    enable = 1'b1;
    for (int t = 1; t <= 35; t++) begin
      tick_n(1);
      exp = (t % 10 == 0);
      checks++;
      if (next !== exp) begin
        errors++; $display("FAIL tick_run t=%0d next=%b want=%b", t, next, exp);
      end
    end
    enable = 1'b0; tick_n(1);
    enable = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      tick_n(1);
      exp = (t == 10 || t == 20 || t == 37);
      checks++;
      if (next !== exp) begin
        errors++; $display("FAIL tick_gap t=%0d next=%b want=%b", t, next, exp);
      end
      if (t == 25) enable = 1'b0;
      if (t == 27) enable = 1'b1;
    end
  endtask

  task automatic test_tone();
    sound = 4'd1;
    for (int t = 1; t <= 130; t++) begin
      tick_n(1);
      exp = 1'(((t - 1) / 40) % 2);
      checks++;
      if (speaker !== exp || tone_active !== 1'b1) begin
        errors++; $display("FAIL tone1 t=%0d spk=%b act=%b want spk=%b act=1", t, speaker, tone_active, exp);
      end
    end
    sound = 4'd15;
    for (int t = 1; t <= 40; t++) begin
      tick_n(1);
      exp = 1'(((t - 1) / 12) % 2);
      checks++;
      if (speaker !== exp || tone_active !== 1'b1) begin
        errors++; $display("FAIL tone15 t=%0d spk=%b act=%b want spk=%b act=1", t, speaker, tone_active, exp);
      end
    end
  endtask

  task automatic test_code_change();
    sound = 4'd1;
    for (int t = 1; t <= 65; t++) begin
      tick_n(1);
      exp = 1'(((t - 1) / 40) % 2);
      checks++;
      if (speaker !== exp) begin
        errors++; $display("FAIL chg_pre t=%0d spk=%b want=%b", t, speaker, exp);
      end
    end
    sound = 4'd8;
    for (int t = 1; t <= 40; t++) begin
      tick_n(1);
      exp = 1'(((t - 1) / 26) % 2);
      checks++;
      if (speaker !== exp) begin
        errors++; $display("FAIL chg_post t=%0d spk=%b want=%b", t, speaker, exp);
      end
    end
  endtask

  task automatic test_mute();
    mute = 1'b1;
    for (int t = 1; t <= 5; t++) begin
      tick_n(1);
      checks++;
      if (speaker !== 1'b0 || tone_active !== 1'b0) begin
        errors++; $display("FAIL mute_on t=%0d spk=%b act=%b want 0 0", t, speaker, tone_active);
      end
    end
    mute = 1'b0;
    for (int t = 1; t <= 40; t++) begin
      tick_n(1);
      exp = 1'((t / 26) % 2);
      checks++;
      if (speaker !== exp || tone_active !== 1'b1) begin
        errors++; $display("FAIL mute_off t=%0d spk=%b act=%b want spk=%b act=1", t, speaker, tone_active, exp);
      end
    end
    sound = 4'd0;
    for (int t = 1; t <= 5; t++) begin
      tick_n(1);
      checks++;
      if (speaker !== 1'b0 || tone_active !== 1'b0) begin
        errors++; $display("FAIL silence t=%0d spk=%b act=%b want 0 0", t, speaker, tone_active);
      end
    end
    sound = 4'd8;
    for (int t = 1; t <= 30; t++) begin
      tick_n(1);
      exp = 1'(((t - 1) / 26) % 2);
      checks++;
      if (speaker !== exp || tone_active !== 1'b1) begin
        errors++; $display("FAIL unsilence t=%0d spk=%b act=%b want spk=%b act=1", t, speaker, tone_active, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    enable = 1'b0; tick_n(1);
    enable = 1'b1; sound = 4'd3;
    tick_n(45);
    checks++;
    if ({next, speaker, tone_active} !== 3'b011) begin
      errors++; $display("FAIL mid_pre outs=%b want=011", {next, speaker, tone_active});
    end
    reset = 1'b0;
    tick_n(1);
    checks++;
    if ({next, speaker, tone_active} !== 3'b000) begin
      errors++; $display("FAIL mid_reset outs=%b want=000", {next, speaker, tone_active});
    end
    reset = 1'b1;
    for (int t = 1; t <= 45; t++) begin
      tick_n(1);
      exp = (t % 10 == 0);
      checks++;
      if (next !== exp) begin
        errors++; $display("FAIL mid_tick t=%0d next=%b want=%b", t, next, exp);
      end
      exp = 1'(((t - 1) / 36) % 2);
      checks++;
      if (speaker !== exp || tone_active !== 1'b1) begin
        errors++; $display("FAIL mid_tone t=%0d spk=%b act=%b want spk=%b act=1", t, speaker, tone_active, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_tick();
    test_tone();
    test_code_change();
    test_mute();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
